// File: rtl/spi_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_rx_pkg
// Purpose  : Shared constants, state encoding and helpers for spi_byte_receiver.
// Revision : 1.0 - initial release
// ============================================================================
package spi_rx_pkg;

    localparam int BYTE_W    = 8;
    // Three bits count 0..7; the extra bit leaves headroom for a terminal-count check.
    localparam int BIT_CNT_W = $clog2(BYTE_W) + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
        return cnt == BIT_CNT_W'(BYTE_W - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_rx_sync
// Purpose  : SYNC_STAGES-deep input synchroniser with rising-edge detect.
// Revision : 1.0 - initial release
// ============================================================================
module spi_rx_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_din,
    output logic o_sync,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    // Resetting to the line's idle level keeps reset release from looking like an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
            r_prev  <= RESET_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_din};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];
    assign o_rise = r_chain[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_receiver
// Purpose  : Oversampling SPI (mode 3, MSB first) byte receiver with
//            valid/ack handshake, overrun and framing-error reporting.
//            Optional macro SPI_BYTE_RECEIVER_DC_EN adds spi_dc / data_is_cmd.
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_receiver
    import spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_data,
`ifdef SPI_BYTE_RECEIVER_DC_EN
    input  logic              spi_dc,
`endif
    input  logic              data_ack,
    output logic [BYTE_W-1:0] data_out,
`ifdef SPI_BYTE_RECEIVER_DC_EN
    output logic              data_is_cmd,
`endif
    output logic              data_valid,
    output logic              overrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int                  c_IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_TIMEOUT - 1);

    rx_state_t             r_state;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [BYTE_W-2:0]     r_shift;
    logic [c_IDLE_W-1:0]   r_idle_cnt;

    logic w_clk_rise;
    logic w_bit;
    logic w_byte_done;
    logic w_unused_clk_lvl;
    logic w_unused_data_rise;

    spi_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_clk (
        .clock  (clock),
        .reset  (reset),
        .i_din  (spi_clk),
        .o_sync (w_unused_clk_lvl),
        .o_rise (w_clk_rise)
    );

    spi_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_data (
        .clock  (clock),
        .reset  (reset),
        .i_din  (spi_data),
        .o_sync (w_bit),
        .o_rise (w_unused_data_rise)
    );

    assign w_byte_done = (r_state == SHIFT) && w_clk_rise && is_last_bit(r_bit_cnt);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_idle_cnt <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            if (data_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_idle_cnt <= '0;
                    if (w_clk_rise) begin
                        r_shift   <= {{(BYTE_W-2){1'b0}}, w_bit};
                        r_bit_cnt <= BIT_CNT_W'(1);
                        r_state   <= SHIFT;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (w_clk_rise) begin
                        // An edge always beats a coincident timeout.
                        r_idle_cnt <= '0;
                        if (w_byte_done) begin
                            data_out   <= {r_shift, w_bit};
                            data_valid <= 1'b1;
                            // A same-cycle ack consumes the old byte, so no overrun.
                            overrun    <= data_valid && !data_ack;
                            r_bit_cnt  <= '0;
                            r_state    <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            r_shift   <= {r_shift[BYTE_W-3:0], w_bit};
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end else if (r_idle_cnt == c_IDLE_LAST) begin
                        frame_err  <= 1'b1;
                        r_idle_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_BYTE_RECEIVER_DC_EN
    logic w_dc;
    logic w_unused_dc_rise;

    spi_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_dc (
        .clock  (clock),
        .reset  (reset),
        .i_din  (spi_dc),
        .o_sync (w_dc),
        .o_rise (w_unused_dc_rise)
    );

    // OLED D/C is low for commands, so the flag is the inverted line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_is_cmd <= 1'b0;
        end else if (w_byte_done) begin
            data_is_cmd <= ~w_dc;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_byte_receiver
// Purpose  : Scoreboard bench for spi_byte_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_byte_receiver;

    localparam int SYNC_STAGES  = 2;
    localparam int IDLE_TIMEOUT = 64;
    localparam int HALF         = 5;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       spi_clk  = 1'b1;
    logic       spi_data = 1'b0;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;
`ifdef SPI_BYTE_RECEIVER_DC_EN
    logic       spi_dc   = 1'b0;
    logic       data_is_cmd;
`endif

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         fe_count = 0;
    logic       prev_busy = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] sb_item;

    spi_byte_receiver #(
        .SYNC_STAGES  (SYNC_STAGES),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_data    (spi_data),
`ifdef SPI_BYTE_RECEIVER_DC_EN
        .spi_dc      (spi_dc),
        .data_is_cmd (data_is_cmd),
`endif
        .data_ack    (data_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte completion drops busy without a frame_err; that is when the scoreboard pops.
    always @(negedge clock) begin
        if (frame_err === 1'b1) fe_count++;
        if (reset === 1'b1 && prev_busy === 1'b1 && busy === 1'b0 && frame_err === 1'b0) begin
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                sb_item = exp_q.pop_front();
                check("sb_data", data_out, sb_item[7:0]);
                check("sb_valid", data_valid, 1);
`ifdef SPI_BYTE_RECEIVER_DC_EN
                check("sb_cmd", data_is_cmd, sb_item[8]);
`endif
            end
        end
        prev_busy = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        spi_clk  = 1'b0;
        spi_data = b;
        tick(HALF);
        spi_clk  = 1'b1;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc, input bit check_lat, input bit ack_at_done);
        exp_q.push_back({~dc, b});
`ifdef SPI_BYTE_RECEIVER_DC_EN
        spi_dc = dc;
`endif
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        spi_clk  = 1'b0;
        spi_data = b[0];
        tick(HALF);
        spi_clk  = 1'b1;
        for (int k = 1; k <= HALF; k++) begin
            tick(1);
            if (check_lat && k == SYNC_STAGES)     check("lat_not_early", data_valid, 0);
            if (check_lat && k == SYNC_STAGES + 1) check("lat_valid", data_valid, 1);
            if (ack_at_done && k == SYNC_STAGES)     data_ack = 1'b1;
            if (ack_at_done && k == SYNC_STAGES + 1) data_ack = 1'b0;
        end
    endtask

    task automatic do_ack();
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        check("ack_valid_clr", data_valid, 0);
        check("ack_ovr_clr", overrun, 0);
    endtask

    int fe0;
    int first_fe;

    initial begin
        tick(3);
        check("rst_data", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_ovr", overrun, 0);
        check("rst_fe", frame_err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        tick(3);
        check("post_rst_busy", busy, 0);

        // Single byte with exact latency
        send_byte(8'hA5, 1'b0, 1'b1, 1'b0);
        check("a5_data", data_out, 8'hA5);
        check("a5_ovr", overrun, 0);
        do_ack();

        // Back-to-back without ack: newest wins, overrun set
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0, 1'b0);
        check("ovr_data", data_out, 8'hC3);
        check("ovr_valid", data_valid, 1);
        check("ovr_flag", overrun, 1);
        do_ack();

        // Partial byte then idle timeout
        fe0 = fe_count;
        first_fe = -1;
        send_bit(1'b1);
        send_bit(1'b0);
        spi_clk  = 1'b0;
        spi_data = 1'b1;
        tick(HALF);
        spi_clk  = 1'b1;
        for (int k = 1; k <= IDLE_TIMEOUT + 20; k++) begin
            tick(1);
            if (frame_err === 1'b1 && first_fe < 0) first_fe = k;
        end
        check("fe_pulses", fe_count - fe0, 1);
        check("fe_not_early", first_fe >= IDLE_TIMEOUT, 1);
        check("fe_not_late", first_fe <= IDLE_TIMEOUT + SYNC_STAGES + 3, 1);
        check("fe_busy", busy, 0);
        check("fe_keeps_data", data_out, 8'hC3);
        check("fe_keeps_valid", data_valid, 0);
        send_byte(8'h81, 1'b0, 1'b0, 1'b0);
        check("after_fe_data", data_out, 8'h81);
        check("after_fe_ovr", overrun, 0);
        do_ack();

        // Ack coincides with completion while the previous byte is still pending
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        check("p11_valid", data_valid, 1);
        send_byte(8'h55, 1'b0, 1'b0, 1'b1);
        check("sim_data", data_out, 8'h55);
        check("sim_valid", data_valid, 1);
        check("sim_ovr", overrun, 0);

        // Reset mid-byte, byte 0x55 still pending
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_data", data_out, 0);
        check("mid_rst_valid", data_valid, 0);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_fe", frame_err, 0);
        check("mid_rst_busy", busy, 0);
        tick(3);
        reset = 1'b1;
        tick(2);
        fe0 = fe_count;
        send_byte(8'hF0, 1'b0, 1'b0, 1'b0);
        check("f0_data", data_out, 8'hF0);
        check("f0_no_fe", fe_count - fe0, 0);
        do_ack();

`ifdef SPI_BYTE_RECEIVER_DC_EN
        send_byte(8'hAF, 1'b0, 1'b0, 1'b0);
        check("dc_af_data", data_out, 8'hAF);
        check("dc_af_cmd", data_is_cmd, 1);
        do_ack();
        send_byte(8'h12, 1'b1, 1'b0, 1'b0);
        check("dc_12_data", data_out, 8'h12);
        check("dc_12_cmd", data_is_cmd, 0);
        do_ack();
`endif

        tick(4);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
